// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the SRAM controller.
package sram_ctrl_pkg;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;
endpackage

// File: rtl/sram_read_buffer.sv
// One-entry buffer of the last completed read (word + data); present only
// when SRAM_READ_BYPASS_EN is defined.
`ifdef SRAM_READ_BYPASS_EN
module sram_read_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [16:0] fill_word,
  input  logic [31:0] fill_data,
  input  logic        inval,
  input  logic [16:0] inval_word,
  input  logic [16:0] lookup_word,
  output logic        hit,
  output logic [31:0] data
);
  logic        valid;
  logic [16:0] word_q;
  logic [31:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      word_q <= '0;
      data_q <= '0;
    end else if (fill) begin
      valid  <= 1'b1;
      word_q <= fill_word;
      data_q <= fill_data;
    end else if (inval && (inval_word == word_q)) begin
      valid <= 1'b0;
    end
  end

  assign hit  = valid && (lookup_word == word_q);
  assign data = data_q;
endmodule
`endif

// File: rtl/sram_ctrl.sv
// 32-bit load/store to a 16-bit SRAM as two half-word phases.
// Optional read bypass buffer: SRAM_READ_BYPASS_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic [31:0]          address,
  input  logic [31:0]          writeData,
  output logic [31:0]          readData,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic [SRAM_DW-1:0]   SRAM_DQ_O,
  input  logic [SRAM_DW-1:0]   SRAM_DQ_I,
  output logic                 SRAM_DQ_OE,
  output logic                 SRAM_WE_N
);
  state_t             state, state_nx;
  logic [2:0]         cnt;
  logic               is_write;
  logic [SRAM_AW-2:0] word_q, word_in;
  logic [31:0]        wdata_q;
  logic               req, last, hit_rd;
  logic [31:0]        hit_data;

  assign req     = MEM_R_EN || MEM_W_EN;
  assign word_in = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  assign last    = (cnt == 3'(WAIT_CYCLES - 1));

`ifdef SRAM_READ_BYPASS_EN
  logic buf_hit;

  sram_read_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .fill        ((state == HIGH) && last && !is_write),
    .fill_word   (word_q),
    .fill_data   ({SRAM_DQ_I, readData[15:0]}),
    .inval       ((state == IDLE) && MEM_W_EN),
    .inval_word  (word_in),
    .lookup_word (word_in),
    .hit         (buf_hit),
    .data        (hit_data)
  );

  assign hit_rd = MEM_R_EN && !MEM_W_EN && buf_hit;
`else
  assign hit_rd   = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = hit_rd ? DONE : LOW;
      LOW:     if (last) state_nx = HIGH;
      HIGH:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      readData <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 3'd0 : cnt + 3'd1;
      if ((state == IDLE) && req) begin
        word_q   <= word_in;
        wdata_q  <= writeData;
        is_write <= MEM_W_EN;
        if (hit_rd) readData <= hit_data;
      end
      if ((state == LOW) && last && !is_write) readData[15:0]  <= SRAM_DQ_I;
      if ((state == HIGH) && last && !is_write) readData[31:16] <= SRAM_DQ_I;
    end
  end

  // Word address is held through IDLE/DONE; reset maps it to word 0.
  always_comb begin
    ready      = (state == DONE) || ((state == IDLE) && !req);
    SRAM_ADDR  = {word_q, (state == HIGH)};
    SRAM_DQ_O  = '0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    if (is_write && ((state == LOW) || (state == HIGH))) begin
      SRAM_DQ_O  = (state == LOW) ? wdata_q[15:0] : wdata_q[31:16];
      SRAM_DQ_OE = 1'b1;
      SRAM_WE_N  = 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, corner sequences and
// randomized traffic against a word-level memory model.
module tb_sram_ctrl;
  localparam int unsigned BASE = 1024;
`ifdef SRAM_READ_BYPASS_EN
  localparam int HIT_LAT = 1;
  localparam bit BYP     = 1'b1;
`else
  localparam int HIT_LAT = 3;
  localparam bit BYP     = 1'b0;
`endif
  localparam int FULL_LAT = 2 * 1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] address = '0, wdata = '0, rdata;
  logic        ready, oe, we_n;
  logic [17:0] sram_addr;
  logic [15:0] dq_o, dq_i;

  logic        r3 = 1'b0;
  logic [31:0] rdata3;
  logic        ready3, oe3, we_n3;
  logic [17:0] sram_addr3;
  logic [15:0] dq_o3;

  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .address(address), .writeData(wdata), .readData(rdata), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_DQ_O(dq_o), .SRAM_DQ_I(dq_i),
    .SRAM_DQ_OE(oe), .SRAM_WE_N(we_n)
  );

  sram_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) dut3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r3), .MEM_W_EN(1'b0),
    .address(32'd1032), .writeData(32'h0), .readData(rdata3), .ready(ready3),
    .SRAM_ADDR(sram_addr3), .SRAM_DQ_O(dq_o3), .SRAM_DQ_I(16'hA5A5),
    .SRAM_DQ_OE(oe3), .SRAM_WE_N(we_n3)
  );

  logic [15:0] sram [0:1023];
  always @(posedge clk) if (!we_n) sram[sram_addr[9:0]] <= dq_o;
  assign dq_i = sram[sram_addr[9:0]];

  int checks = 0, failures = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;
  bit          bp_valid = 1'b0;
  int          bp_word = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_get(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic model_txn(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
    int word;
    word = int'((a - 32'(BASE)) >> 2);
    if (w) begin
      ref_mem[word] = d;
      if (bp_valid && bp_word == word) bp_valid = 1'b0;
      lat = FULL_LAT;
    end else if (r) begin
      lat = (BYP && bp_valid && bp_word == word) ? 1 : FULL_LAT;
      last_rd  = mem_get(word);
      bp_valid = 1'b1;
      bp_word  = word;
    end else begin
      lat = 0;
    end
  endtask

  task automatic run_txn(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit hold,
                         output int lat, output bit we_seen);
    @(negedge clk);
    r_en = r; w_en = w; address = a; wdata = d;
    #1;
    lat = -1; we_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (!we_n) we_seen = 1'b1;
      if (ready) begin lat = k; break; end
      if (!hold && k >= 1) begin r_en = 1'b0; w_en = 1'b0; end
    end
    r_en = 1'b0; w_en = 1'b0;
  endtask

  task automatic txn_check(input string name, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d, input bit hold);
    int  exp_lat, lat;
    bit  we_seen;
    model_txn(r, w, a, d, exp_lat);
    run_txn(r, w, a, d, hold, lat, we_seen);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " readData"}, rdata, last_rd);
    check({name, " we_n activity"}, 32'(we_seen), 32'(w));
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   lat, mlat;
    bit   we_seen;

    for (int i = 0; i < 1024; i++) sram[i] = 16'h0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset readData", rdata, 32'h0);
    check("reset we_n", 32'(we_n), 32'd1);
    check("reset sram_addr", 32'(sram_addr), 32'h0);
    check("reset dq_o", 32'(dq_o), 32'h0);
    check("reset dq_oe", 32'(oe), 32'h0);

    // Write 0xDEADBEEF at 1028, released after cycle 1.
    @(negedge clk);
    w_en = 1'b1; address = 32'd1028; wdata = 32'hDEADBEEF;
    #1;
    check("wr c0 ready", 32'(ready), 32'd0);
    @(negedge clk); #1;
    check("wr c1 addr", 32'(sram_addr), 32'h00002);
    check("wr c1 dq_o", 32'(dq_o), 32'hBEEF);
    check("wr c1 we_n", 32'(we_n), 32'd0);
    check("wr c1 oe", 32'(oe), 32'd1);
    w_en = 1'b0;
    @(negedge clk); #1;
    check("wr c2 addr", 32'(sram_addr), 32'h00003);
    check("wr c2 dq_o", 32'(dq_o), 32'hDEAD);
    check("wr c2 we_n", 32'(we_n), 32'd0);
    @(negedge clk); #1;
    check("wr c3 ready", 32'(ready), 32'd1);
    ref_mem[1] = 32'hDEADBEEF;

    vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, FULL_LAT};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, HIT_LAT};
    vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h11112222, 32'hDEADBEEF, FULL_LAT};
    vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, HIT_LAT};
    vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF, FULL_LAT};
    vecs[5] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hCAFEF00D, FULL_LAT};
    vecs[6] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11112222, FULL_LAT};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h00000000, FULL_LAT};
    for (int i = 0; i < 8; i++) begin
      model_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, mlat);
      run_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, 1'b1, lat, we_seen);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d readData", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d we_n activity", i), 32'(we_seen), 32'(vecs[i].w));
    end

    // Request held through DONE: next cycle is IDLE, re-accepted one later.
    @(negedge clk);
    w_en = 1'b1; address = 32'd1036; wdata = 32'h01234567;
    #1;
    repeat (3) begin @(negedge clk); #1; end
    check("hold done ready", 32'(ready), 32'd1);
    @(negedge clk); #1;
    check("hold idle we_n", 32'(we_n), 32'd1);
    check("hold idle ready", 32'(ready), 32'd0);
    @(negedge clk); #1;
    check("hold relow we_n", 32'(we_n), 32'd0);
    w_en = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    check("hold second done", 32'(ready), 32'd1);
    model_txn(1'b0, 1'b1, 32'd1036, 32'h01234567, mlat);

    // WAIT_CYCLES=3 instance: 7-cycle latency, each half held 3 cycles.
    @(negedge clk);
    r3 = 1'b1;
    #1;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      check($sformatf("w3 c%0d ready", k), 32'(ready3), (k == 7) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 3) check($sformatf("w3 c%0d addr", k), 32'(sram_addr3), 32'h4);
      if (k >= 4 && k <= 6) check($sformatf("w3 c%0d addr", k), 32'(sram_addr3), 32'h5);
      if (k >= 1) r3 = 1'b0;
    end
    check("w3 readData", rdata3, 32'hA5A5A5A5);
    check("w3 we_n", 32'(we_n3), 32'd1);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a    = 32'(BASE) + 32'($urandom_range(0, 3) * 4);
      txn_check($sformatf("rnd%0d", i), kind != 1, kind != 0, a, $urandom, bit'($urandom_range(0, 1)));
    end

    // Reset during HIGH phase of a write.
    @(negedge clk);
    w_en = 1'b1; address = 32'd1424; wdata = 32'h5A5A0F0F;
    #1;
    repeat (2) begin @(negedge clk); #1; end
    check("rst pre we_n", 32'(we_n), 32'd0);
    rst = 1'b1; w_en = 1'b0;
    @(negedge clk); #1;
    check("rst we_n", 32'(we_n), 32'd1);
    check("rst ready", 32'(ready), 32'd1);
    check("rst readData", rdata, 32'h0);
    check("rst sram_addr", 32'(sram_addr), 32'h0);
    check("rst dq_oe", 32'(oe), 32'd0);
    rst = 1'b0;
    ref_mem[100] = 32'h5A5A0F0F;
    last_rd  = '0;
    bp_valid = 1'b0;
    txn_check("post rst read", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
